// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared types and address-map constants for the peripheral
// bus arbiter and its region decoder.
package periph_bus_pkg;

    // Arbiter sequencing states, kept as plain constants of a 2-bit type
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_ACCESS = 2'd1;
    localparam arb_state_t ST_RESP   = 2'd2;

    // Slave regions reachable through the shared bus
    typedef enum logic [1:0] {
        REGION_DMEM  = 2'd0,
        REGION_TBMAN = 2'd1,
        REGION_TIMER = 2'd2,
        REGION_NONE  = 2'd3
    } region_t;

    // DMEM is matched on the top nibble, the small peripherals on a 4 KiB page
    localparam logic [3:0]  DMEM_MATCH  = 4'h1;
    localparam logic [19:0] TBMAN_MATCH = 20'h8000F;
    localparam logic [19:0] TIMER_MATCH = 20'h80001;

    // Priority-ordered address decode: DMEM first, then TBMAN, then TIMER
    function automatic region_t decode_region(input logic [31:0] addr);
        region_t region;
        region = REGION_NONE;
        if (addr[31:28] == DMEM_MATCH) begin
            region = REGION_DMEM;
        end else if (addr[31:12] == TBMAN_MATCH) begin
            region = REGION_TBMAN;
        end else if (addr[31:12] == TIMER_MATCH) begin
            region = REGION_TIMER;
        end
        return region;
    endfunction

endpackage

// File: rtl/periph_region_decode.sv
// periph_region_decode: purely combinational address decoder producing
// active-low region selects and an unmapped flag. Outputs are not qualified
// by any valid; the arbiter gates them with s_valid.
module periph_region_decode
    import periph_bus_pkg::*;
(
    input  logic [31:0] addr,
    output logic        dmem_sel_n,
    output logic        tbman_sel_n,
    output logic        timer_sel_n,
    output logic        unmapped
);

    region_t region;

    // Map the address to a region and fan that out into one-hot-low selects
    always_comb begin
        region      = decode_region(addr);
        dmem_sel_n  = (region != REGION_DMEM);
        tbman_sel_n = (region != REGION_TBMAN);
        timer_sel_n = (region != REGION_TIMER);
        unmapped    = (region == REGION_NONE);
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin arbiter and single-outstanding
// sequencer for the shared peripheral bus (IDLE -> ACCESS -> RESP).
// Optional feature macro: PERIPH_ARB_TIMEOUT_EN enables the ACCESS timeout
// counter and its error completion; without it ACCESS waits for s_ready.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_valid,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_be,
    output logic        cs_dmem_n,
    output logic        cs_tbman_n,
    output logic        cs_timer_n,
    input  logic        s_ready,
    input  logic [31:0] s_rdata
);

    arb_state_t  state_q, state_d;
    // The most recent grantee is also the owner of the transaction in flight,
    // so one register serves both round-robin history and response routing.
    logic        last_owner_q, last_owner_d;
    logic        s_we_q, s_we_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic [3:0]  s_be_q, s_be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        dmem_sel_n, tbman_sel_n, timer_sel_n, unmapped;
    logic        tmo_expired;

`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // The counter holds the number of ACCESS cycles already spent, so the
    // last permitted cycle is the one where it reads TIMEOUT_CYCLES-1.
    assign tmo_expired = (tmo_cnt_q == CNT_LAST);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign tmo_expired        = 1'b0;
`endif

    periph_region_decode u_decode (
        .addr        (s_addr_q),
        .dmem_sel_n  (dmem_sel_n),
        .tbman_sel_n (tbman_sel_n),
        .timer_sel_n (timer_sel_n),
        .unmapped    (unmapped)
    );

    // Round-robin grant, only offered while idle and never during reset
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (state_q == ST_IDLE && !rst) begin
            if (m0_req && m1_req) begin
                m0_gnt = last_owner_q;
                m1_gnt = !last_owner_q;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Next-state logic: capture on grant, complete in ACCESS, respond in RESP
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        s_we_d       = s_we_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_be_d       = s_be_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
`ifdef PERIPH_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m0_gnt || m1_gnt) begin
                    last_owner_d = m1_gnt;
                    s_we_d       = m1_gnt ? m1_we    : m0_we;
                    s_addr_d     = m1_gnt ? m1_addr  : m0_addr;
                    s_wdata_d    = m1_gnt ? m1_wdata : m0_wdata;
                    s_be_d       = m1_gnt ? m1_be    : m0_be;
                    state_d      = ST_ACCESS;
`ifdef PERIPH_ARB_TIMEOUT_EN
                    tmo_cnt_d    = '0;
`endif
                end
            end
            ST_ACCESS: begin
                if (unmapped) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (s_ready) begin
                    rdata_d = s_we_q ? 32'h0 : s_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
`ifdef PERIPH_ARB_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_be_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
`ifdef PERIPH_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_be_q       <= s_be_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
`ifdef PERIPH_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign s_valid    = (state_q == ST_ACCESS);
    assign s_we       = s_we_q;
    assign s_addr     = s_addr_q;
    assign s_wdata    = s_wdata_q;
    assign s_be       = s_be_q;
    assign cs_dmem_n  = !s_valid || dmem_sel_n;
    assign cs_tbman_n = !s_valid || tbman_sel_n;
    assign cs_timer_n = !s_valid || timer_sel_n;

    assign m0_rvalid  = (state_q == ST_RESP) && !last_owner_q;
    assign m1_rvalid  = (state_q == ST_RESP) && last_owner_q;
    assign m0_rdata   = m0_rvalid ? rdata_q : 32'h0;
    assign m1_rdata   = m1_rvalid ? rdata_q : 32'h0;
    assign m0_err     = m0_rvalid && err_q;
    assign m1_err     = m1_rvalid && err_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of arbitration, decode and responses.
// Build with PERIPH_ARB_TIMEOUT_EN defined to exercise the timeout path.
module tb_periph_bus_arbiter;

    localparam int unsigned TB_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_we, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic        cs_dmem_n, cs_tbman_n, cs_timer_n;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .cs_dmem_n(cs_dmem_n), .cs_tbman_n(cs_tbman_n), .cs_timer_n(cs_timer_n),
        .s_ready(s_ready), .s_rdata(s_rdata)
    );

    // Advance one full cycle, returning just after the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive every master and slave input to its quiet value
    task automatic clear_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
        s_ready = 0; s_rdata = 0;
    endtask

    // Address map as ranges: 0 DMEM, 1 TBMAN, 2 TIMER, 3 unmapped
    function automatic int exp_region(input logic [31:0] a);
        if (a >= 32'h1000_0000 && a <= 32'h1FFF_FFFF) return 0;
        if (a >= 32'h8000_F000 && a <= 32'h8000_FFFF) return 1;
        if (a >= 32'h8000_1000 && a <= 32'h8000_1FFF) return 2;
        return 3;
    endfunction

    // Random address drawn from mapped regions and near-miss holes
    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
            1: return 32'h8000_F000 | ($urandom & 32'h0000_0FFC);
            2: return 32'h8000_1000 | ($urandom & 32'h0000_0FFC);
            3: return 32'h3000_0000 | ($urandom & 32'h0FFF_FFFC);
            default: return 32'h8000_2000 | ($urandom & 32'h0000_0FFC);
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        compared++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) begin mismatched++; $display("[TB] FAIL rst_gnt_rvalid: got %b want 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
        compared++; if ({m0_err, m1_err, s_valid, s_we} !== 4'b0) begin mismatched++; $display("[TB] FAIL rst_err_valid_we: got %b want 0000", {m0_err, m1_err, s_valid, s_we}); end
        compared++; if ({cs_dmem_n, cs_tbman_n, cs_timer_n} !== 3'b111) begin mismatched++; $display("[TB] FAIL rst_cs: got %b want 111", {cs_dmem_n, cs_tbman_n, cs_timer_n}); end
        compared++; if (s_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_s_addr: got %h want 0", s_addr); end
        compared++; if (s_wdata !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_s_wdata: got %h want 0", s_wdata); end
        compared++; if (s_be !== 4'h0) begin mismatched++; $display("[TB] FAIL rst_s_be: got %h want 0", s_be); end
        compared++; if ({m0_rdata, m1_rdata} !== 64'h0) begin mismatched++; $display("[TB] FAIL rst_rdata: got %h/%h want 0", m0_rdata, m1_rdata); end
        rst = 1'b0;
        tick();
    endtask

    // Both masters hold requests from reset; grants must alternate m0, m1, ...
    task automatic test_round_robin();
        logic        exp_owner;
        logic        own_rv, oth_rv;
        logic [31:0] own_rd;
        m0_addr = 32'h1000_0100; m0_we = 0; m0_be = 4'hF;
        m1_addr = 32'h8000_F008; m1_we = 0; m1_be = 4'hF;
        m0_req = 1; m1_req = 1; s_ready = 1;
        for (int i = 0; i < 4; i++) begin
            exp_owner = (i % 2) == 1;
            s_rdata = 32'hA5A5_0000 + i;
            #1;
            compared++; if ({m0_gnt, m1_gnt} !== {!exp_owner, exp_owner}) begin mismatched++; $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", i, {m0_gnt, m1_gnt}, {!exp_owner, exp_owner}); end
            tick();
            compared++; if (s_addr !== (exp_owner ? m1_addr : m0_addr)) begin mismatched++; $display("[TB] FAIL rr_s_addr[%0d]: got %h want %h", i, s_addr, exp_owner ? m1_addr : m0_addr); end
            tick();
            own_rv = exp_owner ? m1_rvalid : m0_rvalid;
            oth_rv = exp_owner ? m0_rvalid : m1_rvalid;
            own_rd = exp_owner ? m1_rdata : m0_rdata;
            compared++; if ({own_rv, oth_rv} !== 2'b10) begin mismatched++; $display("[TB] FAIL rr_rvalid[%0d]: got owner/other %b want 10", i, {own_rv, oth_rv}); end
            compared++; if (own_rd !== 32'hA5A5_0000 + i) begin mismatched++; $display("[TB] FAIL rr_rdata[%0d]: got %h want %h", i, own_rd, 32'hA5A5_0000 + i); end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_single_read();
        m0_req = 1; m0_we = 0; m0_addr = 32'h1000_0040; m0_be = 4'hF;
        s_ready = 1; s_rdata = 32'hDEAD_BEEF;
        #1;
        compared++; if ({m0_gnt, m1_gnt} !== 2'b10) begin mismatched++; $display("[TB] FAIL rd_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
        tick();
        m0_req = 0;
        compared++; if ({s_valid, cs_dmem_n, cs_tbman_n, cs_timer_n} !== 4'b1011) begin mismatched++; $display("[TB] FAIL rd_cs: got %b want 1011", {s_valid, cs_dmem_n, cs_tbman_n, cs_timer_n}); end
        tick();
        compared++; if ({m0_rvalid, m0_err, m1_rvalid} !== 3'b100) begin mismatched++; $display("[TB] FAIL rd_resp: got %b want 100", {m0_rvalid, m0_err, m1_rvalid}); end
        compared++; if (m0_rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("[TB] FAIL rd_rdata: got %h want deadbeef", m0_rdata); end
        tick();
        compared++; if (m0_rvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rd_one_shot: got %b want 0", m0_rvalid); end
        clear_inputs();
    endtask

    task automatic test_timer_write();
        m1_req = 1; m1_we = 1; m1_addr = 32'h8000_1004; m1_wdata = 32'h1234_5678; m1_be = 4'b0011;
        s_ready = 1; s_rdata = 32'hFFFF_FFFF;
        #1;
        compared++; if ({m0_gnt, m1_gnt} !== 2'b01) begin mismatched++; $display("[TB] FAIL wr_gnt: got %b want 01", {m0_gnt, m1_gnt}); end
        tick();
        m1_req = 0;
        compared++; if ({cs_dmem_n, cs_tbman_n, cs_timer_n} !== 3'b110) begin mismatched++; $display("[TB] FAIL wr_cs: got %b want 110", {cs_dmem_n, cs_tbman_n, cs_timer_n}); end
        compared++; if ({s_we, s_be, s_wdata} !== {1'b1, 4'b0011, 32'h1234_5678}) begin mismatched++; $display("[TB] FAIL wr_payload: got %b/%b/%h want 1/0011/12345678", s_we, s_be, s_wdata); end
        tick();
        compared++; if ({m1_rvalid, m1_err, m0_rvalid} !== 3'b100) begin mismatched++; $display("[TB] FAIL wr_resp: got %b want 100", {m1_rvalid, m1_err, m0_rvalid}); end
        compared++; if (m1_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL wr_rdata: got %h want 0", m1_rdata); end
        tick();
        clear_inputs();
    endtask

    // Unmapped read completes after one ACCESS cycle even with s_ready high
    task automatic test_unmapped();
        m0_req = 1; m0_we = 0; m0_addr = 32'h2000_0000;
        s_ready = 1; s_rdata = 32'hCAFE_F00D;
        #1;
        compared++; if (m0_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL um_gnt: got %b want 1", m0_gnt); end
        tick();
        m0_req = 0;
        compared++; if ({s_valid, cs_dmem_n, cs_tbman_n, cs_timer_n} !== 4'b1111) begin mismatched++; $display("[TB] FAIL um_cs: got %b want 1111", {s_valid, cs_dmem_n, cs_tbman_n, cs_timer_n}); end
        tick();
        compared++; if ({s_valid, m0_rvalid, m0_err} !== 3'b011) begin mismatched++; $display("[TB] FAIL um_resp: got %b want 011", {s_valid, m0_rvalid, m0_err}); end
        tick();
        clear_inputs();
    endtask

    // Silent slave at TBMAN: timeout error, or indefinite wait without it
    task automatic test_no_response();
        m1_req = 1; m1_we = 0; m1_addr = 32'h8000_F000;
        #1;
        compared++; if (m1_gnt !== 1'b1) begin mismatched++; $display("[TB] FAIL nr_gnt: got %b want 1", m1_gnt); end
        tick();
        m1_req = 0;
`ifdef PERIPH_ARB_TIMEOUT_EN
        for (int k = 1; k <= int'(TB_TIMEOUT); k++) begin
            compared++; if ({s_valid, m1_rvalid} !== 2'b10) begin mismatched++; $display("[TB] FAIL to_wait[%0d]: got %b want 10", k, {s_valid, m1_rvalid}); end
            tick();
        end
        compared++; if ({m1_rvalid, m1_err, m1_rdata} !== {2'b11, 32'h0}) begin mismatched++; $display("[TB] FAIL to_err: got %b%b/%h want 11/0", m1_rvalid, m1_err, m1_rdata); end
        tick();
        m1_req = 1;
        #1;
        tick();
        m1_req = 0;
        for (int k = 1; k <= int'(TB_TIMEOUT); k++) begin
            s_ready = (k == int'(TB_TIMEOUT));
            s_rdata = 32'h0BAD_F00D;
            compared++; if ({s_valid, m1_rvalid} !== 2'b10) begin mismatched++; $display("[TB] FAIL to_late_wait[%0d]: got %b want 10", k, {s_valid, m1_rvalid}); end
            tick();
        end
        s_ready = 0;
        compared++; if ({m1_rvalid, m1_err, m1_rdata} !== {2'b10, 32'h0BAD_F00D}) begin mismatched++; $display("[TB] FAIL to_late_ready: got %b%b/%h want 10/0badf00d", m1_rvalid, m1_err, m1_rdata); end
`else
        for (int k = 1; k <= 40; k++) begin
            compared++; if ({s_valid, m1_rvalid} !== 2'b10) begin mismatched++; $display("[TB] FAIL nw_wait[%0d]: got %b want 10", k, {s_valid, m1_rvalid}); end
            tick();
        end
        s_ready = 1; s_rdata = 32'h0BAD_F00D;
        tick();
        s_ready = 0;
        compared++; if ({m1_rvalid, m1_err, m1_rdata} !== {2'b10, 32'h0BAD_F00D}) begin mismatched++; $display("[TB] FAIL nw_resp: got %b%b/%h want 10/0badf00d", m1_rvalid, m1_err, m1_rdata); end
`endif
        tick();
        clear_inputs();
    endtask

    // Reset in ACCESS kills the transfer; arbitration history restarts
    task automatic test_reset_abort();
        m0_req = 1; m0_we = 0; m0_addr = 32'h8000_F000;
        #1;
        tick();
        compared++; if (s_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL ab_access: got %b want 1", s_valid); end
        rst = 1; s_ready = 1;
        #1;
        compared++; if ({s_valid, cs_tbman_n, m0_rvalid, m0_gnt} !== 4'b0100) begin mismatched++; $display("[TB] FAIL ab_immediate: got %b want 0100", {s_valid, cs_tbman_n, m0_rvalid, m0_gnt}); end
        compared++; if (s_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL ab_s_addr: got %h want 0", s_addr); end
        tick();
        rst = 0; s_ready = 0;
        compared++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin mismatched++; $display("[TB] FAIL ab_no_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
        m1_req = 1; m1_addr = 32'h1000_0000;
        #1;
        compared++; if ({m0_gnt, m1_gnt} !== 2'b10) begin mismatched++; $display("[TB] FAIL ab_regrant: got %b want 10", {m0_gnt, m1_gnt}); end
        tick();
        m0_req = 0; m1_req = 0; s_ready = 1; s_rdata = 32'h5555_AAAA;
        tick();
        s_ready = 0;
        compared++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h5555_AAAA}) begin mismatched++; $display("[TB] FAIL ab_resp: got %b/%h want 1/5555aaaa", m0_rvalid, m0_rdata); end
        tick();
        clear_inputs();
    endtask

    // Randomized transactions against the round-robin / decode / response model
    task automatic test_random();
        int          model_last;
        int          win, reg_id, delay;
        logic [1:0]  reqs;
        logic [31:0] w_addr, w_wdata, exp_rd;
        logic [3:0]  w_be;
        logic        w_we, exp_err;
        logic [2:0]  exp_cs;
        logic        win_rv, los_rv, win_err;
        logic [31:0] win_rd, los_rd;
        rst = 1;
        tick();
        rst = 0;
        model_last = 1;
        for (int t = 0; t < 40; t++) begin
            reqs = 2'($urandom_range(1, 3));
            m0_req = reqs[0]; m0_we = 1'($urandom); m0_addr = pick_addr(); m0_wdata = $urandom; m0_be = 4'($urandom);
            m1_req = reqs[1]; m1_we = 1'($urandom); m1_addr = pick_addr(); m1_wdata = $urandom; m1_be = 4'($urandom);
            if (reqs == 2'b11) win = 1 - model_last;
            else win = reqs[1] ? 1 : 0;
            model_last = win;
            w_we = win ? m1_we : m0_we; w_addr = win ? m1_addr : m0_addr;
            w_wdata = win ? m1_wdata : m0_wdata; w_be = win ? m1_be : m0_be;
            reg_id = exp_region(w_addr);
            exp_cs = {reg_id != 0, reg_id != 1, reg_id != 2};
            delay = $urandom_range(0, 3);
            exp_rd = 32'h0; exp_err = (reg_id == 3);
            #1;
            compared++; if ({m0_gnt, m1_gnt} !== {win == 0, win == 1}) begin mismatched++; $display("[TB] FAIL rnd_gnt[%0d]: got %b want %b", t, {m0_gnt, m1_gnt}, {win == 0, win == 1}); end
            tick();
            m0_req = 0; m1_req = 0;
            for (int k = 0; k < 8; k++) begin
                compared++; if ({s_valid, s_we, s_be, s_addr, s_wdata} !== {1'b1, w_we, w_be, w_addr, w_wdata}) begin mismatched++; $display("[TB] FAIL rnd_payload[%0d]: got %b/%b/%h/%h/%h want 1/%b/%h/%h/%h", t, s_valid, s_we, s_be, s_addr, s_wdata, w_we, w_be, w_addr, w_wdata); end
                compared++; if ({cs_dmem_n, cs_tbman_n, cs_timer_n} !== exp_cs) begin mismatched++; $display("[TB] FAIL rnd_cs[%0d]: got %b want %b", t, {cs_dmem_n, cs_tbman_n, cs_timer_n}, exp_cs); end
                if (reg_id == 3) begin
                    tick();
                    break;
                end
                s_ready = (k == delay);
                s_rdata = $urandom;
                if (k == delay) exp_rd = w_we ? 32'h0 : s_rdata;
                tick();
                if (k == delay) break;
            end
            s_ready = 0;
            win_rv = win ? m1_rvalid : m0_rvalid; los_rv = win ? m0_rvalid : m1_rvalid;
            win_rd = win ? m1_rdata : m0_rdata;   los_rd = win ? m0_rdata : m1_rdata;
            win_err = win ? m1_err : m0_err;
            compared++; if ({win_rv, los_rv, s_valid} !== 3'b100) begin mismatched++; $display("[TB] FAIL rnd_rvalid[%0d]: got %b want 100", t, {win_rv, los_rv, s_valid}); end
            compared++; if ({win_err, win_rd, los_rd} !== {exp_err, exp_rd, 32'h0}) begin mismatched++; $display("[TB] FAIL rnd_resp[%0d]: got %b/%h/%h want %b/%h/0", t, win_err, win_rd, los_rd, exp_err, exp_rd); end
            tick();
            compared++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin mismatched++; $display("[TB] FAIL rnd_idle[%0d]: got %b want 00", t, {m0_rvalid, m1_rvalid}); end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        test_reset();
        test_round_robin();
        test_single_read();
        test_timer_write();
        test_unmapped();
        test_no_response();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter and sequencer for the shared peripheral bus behind the pipeline's load/store unit. It multiplexes the CPU data port (master 0) and a secondary master (master 1, debug/DMA) onto a single slave bus. It decodes the latched address into active-low chip selects for DMEM, TBMAN and TIMER, and returns one response per accepted request. Unmapped addresses and unresponsive slaves complete with an error response instead of hanging the pipeline.

## Interface
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles waiting for `s_ready` before error completion; legal range 2..256.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  request valid; held with its payload until granted.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_be, m1_be  in  4  byte enables.
- m0_gnt, m1_gnt  out  1  request accepted on this edge (combinational, IDLE only).
- m0_rvalid, m1_rvalid  out  1  one-cycle response strobe.
- m0_rdata, m1_rdata  out  32  read data, valid with rvalid.
- m0_err, m1_err  out  1  error flag, valid with rvalid.
- s_valid  out  1  slave access in progress.
- s_we, s_addr[31:0], s_wdata[31:0], s_be[3:0]  out  latched request payload.
- cs_dmem_n, cs_tbman_n, cs_timer_n  out  1 each  active-low chip selects, asserted only while s_valid = 1.
- s_ready  in  1  selected slave completes this cycle.
- s_rdata  in  32  selected slave read data, sampled when s_ready = 1.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If any req is high, grant exactly one master. Assert that master's gnt combinationally, capture its payload and owner index on the edge, and go to ACCESS.
  - With no req, stay in IDLE.
- Arbitration is round-robin:
  - Register `last_owner` resets to 1, so master 0 wins the first contention.
  - With both requesting, the master not equal to `last_owner` wins.
  - A single requester always wins.
  - `last_owner` updates on every grant.
- Decode of latched address:
  - addr[31:28] = 4'h1 selects DMEM.
  - Else addr[31:12] = 20'h8000F selects TBMAN.
  - Else addr[31:12] = 20'h80001 selects TIMER.
  - Anything else is unmapped.
- ACCESS:
  - s_valid = 1; the selected cs_*_n is low and the others are high.
  - Unmapped address: go to RESP with err = 1 after exactly one ACCESS cycle; no cs asserted; s_ready ignored.
  - s_ready = 1: register s_rdata (reads) or 0 (writes), err = 0, go to RESP.
  - Otherwise the timeout counter increments. After TIMEOUT_CYCLES ACCESS cycles without s_ready, go to RESP with err = 1 and rdata = 0.
  - s_ready in the same cycle as the timeout wins: normal completion.
- RESP:
  - Owner's rvalid = 1 for one cycle with its registered rdata/err; return to IDLE.
  - The non-owner's rvalid stays 0 and its rdata reads 0.
- No new grant is issued in ACCESS or RESP; a requester simply holds req.

## Timing
- Request granted at edge T; s_valid high from T+1. If s_ready is seen in cycle T+1, rvalid is in cycle T+2.
- Minimum request-to-response latency is 2 cycles; maximum throughput is one transaction per 3 cycles.
- Reset values: all gnt/rvalid/err = 0, rdata = 0, s_valid = 0, s_we = 0, s_addr/s_wdata = 0, s_be = 0, all cs_*_n = 1, timeout counter = 0, last_owner = 1.
- Reset asserted mid-transaction aborts it immediately. No rvalid is ever issued for the aborted request, and the master must re-request.
- The timeout counter clears on entry to ACCESS. Its width is $clog2(TIMEOUT_CYCLES+1).

## Configuration
- PERIPH_ARB_TIMEOUT_EN defined: timeout counter and timeout error path are present as described.
- Not defined: no counter; ACCESS waits indefinitely for s_ready. Unmapped-address error completion remains.

## Structure
- Shared package periph_bus_pkg holds:
  - FSM state typedef (IDLE/ACCESS/RESP).
  - Region typedef (DMEM/TBMAN/TIMER/NONE).
  - Region match constants: 4'h1 on [31:28]; 20'h8000F and 20'h80001 on [31:12].
- One sub-module, periph_region_decode: combinational, 32-bit address in, three active-low selects plus an `unmapped` flag out. The arbiter gates its outputs with s_valid.

## Test plan
- Single read, m0 at 0x1000_0040, s_ready in first ACCESS cycle, s_rdata = 0xDEADBEEF -> m0_gnt at T, cs_dmem_n low at T+1, m0_rvalid at T+2 with rdata 0xDEADBEEF and err 0.
- m0 and m1 requesting together continuously after reset, slave always ready -> grants alternate m0, m1, m0, m1, each response to the correct master.
- Write by m1 to 0x8000_1004 with be = 4'b0011 -> cs_timer_n low, s_we = 1, s_be = 0011, m1_rvalid with rdata 0 and err 0.
- Read at 0x2000_0000 -> no cs asserted, exactly one ACCESS cycle, rvalid with err 1.
- With PERIPH_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16, s_ready held 0 at 0x8000_F000 -> err response after 16 ACCESS cycles; s_ready on cycle 16 gives err 0.
- rst pulsed during ACCESS -> all outputs at reset values immediately, no rvalid; next req is granted to m0 normally.
